// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared types and helpers for the vectored interrupt
//                controller: handshake FSM state encoding and id width.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Handshake states: waiting for work, requesting the core, handler running
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Width of a source id; a single source still needs one bit
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational lowest-index-wins priority encoder with a
//                valid flag. Index 0 has the highest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    // Scan from the top down so the lowest set index is the last to write
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vectored_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vectored_irq_ctrl
//  Description : N_SRC-source vectored interrupt controller. Level/edge
//                pending capture, mask register, lowest-index priority and a
//                REQ/SERVICE handshake that freezes EAddr until the core
//                acknowledges and blocks nesting until return.
//  Revision    : 1.0 - initial release
// ============================================================================
module vectored_irq_ctrl
    import irq_pkg::*;
#(
    parameter int               N_SRC      = 4,
    parameter logic [N_SRC-1:0] EDGE_MODE  = '0,
    parameter logic [N_SRC-1:0] MASK_RST   = '1,
    parameter logic [31:0]      VEC_BASE   = 32'h0000_0180,
    parameter int               VEC_STRIDE = 8,
    parameter int               ID_W       = id_width(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wd,
    input  logic [N_SRC-1:0] pend_clr,
    input  logic             iack,
    input  logic             ret,
    output logic             irq,
    output logic [31:0]      EAddr,
    output logic [ID_W-1:0]  active_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask
);

    irq_state_e       r_state;
    logic [N_SRC-1:0] r_prev;
    // Low for the first cycle after reset so a line held high across reset
    // release is absorbed into r_prev instead of looking like an edge.
    logic             r_armed;

    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_pend_nxt;
    logic             w_win_valid;
    logic [ID_W-1:0]  w_win_id;
    logic             w_act_elig;
    logic [31:0]      w_vec_addr;

    assign w_eligible = pending & mask;
    assign w_rise     = src_irq & ~r_prev & {N_SRC{r_armed}};
    assign w_ack_clr  = (r_state == ST_REQ && iack) ? (N_SRC'(1) << active_id) : '0;
    assign w_act_elig = |(w_eligible & (N_SRC'(1) << active_id));
    assign w_vec_addr = VEC_BASE + (32'(w_win_id) * 32'(VEC_STRIDE));

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req   (w_eligible),
        .valid (w_win_valid),
        .idx   (w_win_id)
    );

    // Next pending: level bits follow the line, edge bits set-dominant latch
    always_comb begin
        w_pend_nxt = pending;
        for (int i = 0; i < N_SRC; i++) begin
            if (EDGE_MODE[i]) begin
                if (w_rise[i]) begin
                    w_pend_nxt[i] = 1'b1;
                end else if (pend_clr[i] || w_ack_clr[i]) begin
                    w_pend_nxt[i] = 1'b0;
                end
            end else begin
                w_pend_nxt[i] = src_irq[i];
            end
        end
    end

    // Pending, edge-history and mask registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            r_prev  <= '0;
            r_armed <= 1'b0;
            mask    <= MASK_RST;
        end else begin
            pending <= w_pend_nxt;
            r_prev  <= src_irq;
            r_armed <= 1'b1;
            if (mask_we) begin
                mask <= mask_wd;
            end
        end
    end

    // Handshake FSM with registered irq / EAddr / active_id / in_service
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            irq        <= 1'b0;
            in_service <= 1'b0;
            active_id  <= '0;
            EAddr      <= VEC_BASE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        active_id <= w_win_id;
                        EAddr     <= w_vec_addr;
                        irq       <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Acknowledge beats a simultaneous withdrawal
                    if (iack) begin
                        irq        <= 1'b0;
                        in_service <= 1'b1;
                        r_state    <= ST_SERVICE;
                    end else if (!w_act_elig) begin
                        irq     <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (ret) begin
                        in_service <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    irq        <= 1'b0;
                    in_service <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vectored_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vectored_irq_ctrl
//  Description : Self-checking bench for vectored_irq_ctrl (4 sources,
//                source 0 edge mode, sources 1..3 level mode).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vectored_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_irq  = '0;
    logic        mask_we  = 1'b0;
    logic [3:0]  mask_wd  = '0;
    logic [3:0]  pend_clr = '0;
    logic        iack     = 1'b0;
    logic        ret      = 1'b0;
    logic        irq;
    logic [31:0] EAddr;
    logic [1:0]  active_id;
    logic        in_service;
    logic [3:0]  pending;
    logic [3:0]  mask;

    int n_tests = 0;
    int n_fail  = 0;

    vectored_irq_ctrl #(
        .N_SRC      (4),
        .EDGE_MODE  (4'b0001),
        .MASK_RST   (4'b1111),
        .VEC_BASE   (32'h0000_0180),
        .VEC_STRIDE (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .mask_we    (mask_we),
        .mask_wd    (mask_wd),
        .pend_clr   (pend_clr),
        .iack       (iack),
        .ret        (ret),
        .irq        (irq),
        .EAddr      (EAddr),
        .active_id  (active_id),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = requesting, 2 = handler running
    int         m_state = 0;
    int         m_id    = 0;
    logic [3:0] m_pend  = '0;
    logic [3:0] m_mask  = 4'hF;
    logic [3:0] m_prev  = '0;
    bit         m_armed = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] elig;
        logic [3:0] np;
        int         nst;
        int         nid;
        bit         rise;
        bit         clr;
        if (rst) begin
            m_state <= 0;
            m_id    <= 0;
            m_pend  <= '0;
            m_mask  <= 4'hF;
            m_prev  <= '0;
            m_armed <= 1'b0;
        end else begin
            elig = m_pend & m_mask;
            np   = m_pend;
            np[3:1] = src_irq[3:1];
            rise = m_armed && src_irq[0] && !m_prev[0];
            clr  = pend_clr[0] || (m_state == 1 && iack && m_id == 0);
            if (rise)     np[0] = 1'b1;
            else if (clr) np[0] = 1'b0;
            nst = m_state;
            nid = m_id;
            if (m_state == 0) begin
                for (int i = 3; i >= 0; i--) begin
                    if (elig[i]) begin
                        nid = i;
                        nst = 1;
                    end
                end
            end else if (m_state == 1) begin
                if (iack)              nst = 2;
                else if (!elig[m_id])  nst = 0;
            end else if (ret) begin
                nst = 0;
            end
            m_state <= nst;
            m_id    <= nid;
            m_pend  <= np;
            m_prev  <= src_irq;
            m_armed <= 1'b1;
            if (mask_we) m_mask <= mask_wd;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        check("cmp_irq",        irq,        32'(m_state == 1));
        check("cmp_in_service", in_service, 32'(m_state == 2));
        check("cmp_active_id",  active_id,  32'(m_id));
        check("cmp_EAddr",      EAddr,      32'h180 + 32'(m_id) * 32'd8);
        check("cmp_pending",    pending,    32'(m_pend));
        check("cmp_mask",       mask,       32'(m_mask));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        tick();
        check("rst_irq",   irq,        0);
        check("rst_eaddr", EAddr,      32'h180);
        check("rst_mask",  mask,       4'hF);
        check("rst_pend",  pending,    0);
        check("rst_id",    active_id,  0);
        check("rst_insvc", in_service, 0);

        // Level source 2: request, acknowledge, return, re-request
        src_irq = 4'b0100;
        tick();
        check("l2_pend", pending, 4'b0100);
        check("l2_irq0", irq, 0);
        tick();
        check("l2_irq",   irq, 1);
        check("l2_id",    active_id, 2);
        check("l2_eaddr", EAddr, 32'h190);
        iack = 1'b1; tick(); iack = 1'b0;
        check("l2_svc", in_service, 1);
        check("l2_svc_irq", irq, 0);
        tick();
        ret = 1'b1; tick(); ret = 1'b0;
        check("l2_bubble", irq, 0);
        check("l2_idle_svc", in_service, 0);
        tick();
        check("l2_rereq", irq, 1);
        check("l2_rereq_eaddr", EAddr, 32'h190);

        // Withdrawal when the level drops while requesting
        src_irq = 4'b0000;
        tick();
        check("wd_hold", irq, 1);
        tick();
        check("wd_irq", irq, 0);

        // Acknowledge in the cycle the withdrawal would happen: ack wins
        src_irq = 4'b0100;
        tick(2);
        check("ackw_req", irq, 1);
        src_irq = 4'b0000;
        tick();
        iack = 1'b1; tick(); iack = 1'b0;
        check("ackw_svc", in_service, 1);
        ret = 1'b1; tick(); ret = 1'b0;
        tick();
        check("ackw_idle", irq, 0);

        // Simultaneous sources 3 and 1: 1 first, then 3
        src_irq = 4'b1010;
        tick(2);
        check("pri_id",    active_id, 1);
        check("pri_eaddr", EAddr, 32'h188);
        iack = 1'b1; tick(); iack = 1'b0;
        src_irq = 4'b1000;
        ret = 1'b1; tick(); ret = 1'b0;
        tick();
        check("pri_id3",    active_id, 3);
        check("pri_eaddr3", EAddr, 32'h198);
        iack = 1'b1; tick(); iack = 1'b0;
        src_irq = 4'b0000;
        ret = 1'b1; tick(); ret = 1'b0;
        tick();
        check("pri_done", irq, 0);

        // Edge source 0: pulse, hold, set-wins-over-clear, ack clears
        src_irq = 4'b0001; tick(); src_irq = 4'b0000;
        check("e0_pend", pending, 4'b0001);
        tick();
        check("e0_irq",   irq, 1);
        check("e0_eaddr", EAddr, 32'h180);
        tick(2);
        check("e0_hold", pending, 4'b0001);
        src_irq = 4'b0001; pend_clr = 4'b0001;
        tick();
        src_irq = 4'b0000; pend_clr = 4'b0000;
        check("e0_setwins", pending, 4'b0001);
        iack = 1'b1; tick(); iack = 1'b0;
        check("e0_ackclr", pending, 4'b0000);
        ret = 1'b1; tick(); ret = 1'b0;
        tick();
        check("e0_idle", irq, 0);

        // Edge source 0 cleared by pend_clr while requesting: withdraws
        src_irq = 4'b0001; tick(); src_irq = 4'b0000;
        tick();
        pend_clr = 4'b0001; tick(); pend_clr = 4'b0000;
        check("pc_clr", pending, 4'b0000);
        tick();
        check("pc_wd", irq, 0);

        // Mask all, raise all, unmask bit 3
        mask_we = 1'b1; mask_wd = 4'b0000; tick(); mask_we = 1'b0;
        check("m_zero", mask, 0);
        src_irq = 4'hF;
        tick(3);
        check("m_blocked", irq, 0);
        mask_we = 1'b1; mask_wd = 4'b1000; tick(); mask_we = 1'b0;
        check("m_wr", mask, 4'b1000);
        check("m_not_yet", irq, 0);
        tick();
        check("m_irq", irq, 1);
        check("m_id",  active_id, 3);
        iack = 1'b1; tick(); iack = 1'b0;
        check("m_svc", in_service, 1);

        // Asynchronous reset while in service
        #2 rst = 1'b1;
        #1;
        check("ar_irq",   irq, 0);
        check("ar_svc",   in_service, 0);
        check("ar_id",    active_id, 0);
        check("ar_eaddr", EAddr, 32'h180);
        check("ar_pend",  pending, 0);
        check("ar_mask",  mask, 4'hF);
        src_irq = 4'b0001;
        tick();
        rst = 1'b0;
        // Edge line held high across reset release must not register
        tick(2);
        check("ar_noedge", pending, 0);
        check("ar_noirq",  irq, 0);
        src_irq = 4'b0000; tick();
        src_irq = 4'b0001; tick();
        check("ar_edge", pending, 4'b0001);
        src_irq = 4'b0000;
        tick(2);

        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vectored_irq_ctrl.md
# vectored_irq_ctrl

Parametrised, vectored interrupt controller feeding the single-cycle MIPS core's `irq`/`EAddr` inputs and consuming its `iack`/return (`rfe`) strobes. It generalises the single-line, externally-vectored interrupt path to `N_SRC` prioritised sources. Each source is level or edge mode and individually maskable, and each selects its own exception vector. A three-state handshake FSM keeps `EAddr` stable until the core takes the interrupt and blocks further requests until the handler returns.

## Interface
- `N_SRC`, 4, number of sources, 1..32
- `EDGE_MODE`, all zeros, per-source mode bit: 1 = rising-edge captured, 0 = level
- `MASK_RST`, all ones, reset value of the mask register (1 = enabled)
- `VEC_BASE`, 32'h0000_0180, vector of source 0
- `VEC_STRIDE`, 8, byte spacing between vectors; power of two, ≥ 4
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `src_irq`  in  N_SRC  request lines, synchronous to `clk`
- `mask_we`  in  1  mask register write strobe
- `mask_wd`  in  N_SRC  mask write data
- `pend_clr`  in  N_SRC  write-1-to-clear for edge pending bits; ignored for level bits
- `iack`  in  1  core has taken the interrupt (`rfe[1]`)
- `ret`  in  1  core executed return-from-exception (`rfe[0]`)
- `irq`  out  1  interrupt request to core
- `EAddr`  out  32  vector address of the requesting source
- `active_id`  out  clog2(N_SRC) (min 1)  latched source id
- `in_service`  out  1  handler running (state SERVICE)
- `pending`  out  N_SRC  pending register
- `mask`  out  N_SRC  mask register

## Operation
- Pending update, per bit, each cycle:
  - Level sources: `pending[i] <= src_irq[i]`.
  - Edge sources: set on a rising edge of `src_irq[i]`, detected against a registered previous sample. Cleared by `pend_clr[i]` or by `iack` while `active_id == i`. When a set and a clear occur in the same cycle, set wins.
- Eligible vector = `pending & mask`. Winner = lowest eligible index; index 0 has highest priority.
- FSM:
  - IDLE: if eligible ≠ 0, latch winner into `active_id` and move to REQ.
  - REQ: `irq` = 1. `active_id` and `EAddr` are frozen; a higher-priority arrival does not preempt.
    - On `iack`: move to SERVICE.
    - Else, if `active_id` is no longer eligible (level dropped, masked, or cleared): withdraw to IDLE.
    - If `iack` and withdrawal occur in the same cycle, `iack` wins.
  - SERVICE: `irq` = 0 and `in_service` = 1; no new request is raised (no nesting). On `ret`: move to IDLE.
- `iack` outside REQ and `ret` outside SERVICE are ignored.
- `EAddr = VEC_BASE + active_id * VEC_STRIDE`, computed in 32 bits, wraps modulo 2^32.
- Mask write takes effect the following cycle; `mask_we` takes priority over no-op, and there is no partial write.

## Timing
- All outputs are registered. Reset values: `irq` 0, `in_service` 0, `active_id` 0, `EAddr` = `VEC_BASE`, `pending` 0, `mask` = `MASK_RST`, previous-sample register 0, FSM IDLE.
- Request latency: `src_irq` high before edge k → `pending` set after edge k → `irq`/`EAddr` valid after edge k+1. This applies to both modes.
- `iack` sampled at edge n → `irq` = 0 and `in_service` = 1 after edge n.
- `ret` at edge m with eligible work present → IDLE after edge m, `irq` = 1 after edge m+1. This is a one-cycle bubble by design.
- Reset asserted mid-operation (any state) returns all state to reset values immediately. Edges in flight are lost, and an edge source held high across reset deassertion produces no edge.
- `EAddr` must not change while `irq` = 1.

## Structure
- Package `irq_pkg`: FSM state enum (IDLE, REQ, SERVICE) and an id-width function, clog2 with minimum 1.
- Sub-module `irq_prio_enc`, parametrised on `N_SRC`: combinational lowest-index priority encoder with a `valid` output, reused by future multi-level controllers.
- Top: pending/edge logic, mask register, FSM, vector arithmetic.

## Test plan
- Reset with `MASK_RST` all ones; `src_irq[2]` high (level) at edge 1 → `irq` = 1, `active_id` = 2, `EAddr` = 0x190 after edge 2. Pulse `iack` → `in_service` = 1. Pulse `ret` → IDLE, then `irq` = 1 again one cycle later (source 2 still high).
- Sources 3 and 1 assert in the same cycle → `active_id` = 1, `EAddr` = 0x188. After `iack`/`ret`, source 3 is served next with `EAddr` = 0x198.
- Edge source 0 with a 1-cycle pulse → `pending[0]` holds until `iack`. A second edge coinciding with `pend_clr[0]` → bit stays set.
- In REQ for level source 2: drop `src_irq[2]` → `irq` = 0 the next cycle, FSM in IDLE. Repeat with `iack` in the same cycle as the drop → SERVICE.
- `mask_wd` = 0 then raise all sources → `irq` stays 0. Unmask bit 3 → `irq` = 1 two cycles later with `active_id` = 3. Assert `rst` in SERVICE → every output at its reset value.
